tpu_layer_scheduler: RTL and testbench
======================================

# tpu_layer_scheduler

Top-level sequencer for the TPU inference pipeline. Runs the layer engines (conv, full-connect, argmax, …) one after another: enables exactly one layer at a time, gives it a clean reset, waits for its `done`, and accumulates overflow. Owns the shared ROM/RAM address buses and the MultAdder operand buses, muxing them from the active layer. Layers therefore never need tri-state sharing.

## Interface

Parameters:
- `NUM_LAYERS`, 4: number of sequenced layer engines, index 0 runs first.
- `ADDR_W`, 32: ROM/RAM address width.
- `DATA_W`, 1024: MultAdder operand width (128 × 8-bit lanes).
- `RST_CYCLES`, 2: cycles each layer's reset is held before it runs.
- `TIMEOUT_CYCLES`, 4096: max cycles in RUN per layer before abort.

Ports:
- `clk` in 1: sole clock, rising edge.
- `iRst` in 1: synchronous, active-high reset.
- `iStart` in 1: start one inference, sampled in IDLE or DONE.
- `layer_done` in NUM_LAYERS: per-layer done flags.
- `layer_overflow` in NUM_LAYERS: per-layer overflow flags.
- `layer_addr_rom` in NUM_LAYERS×ADDR_W: flattened, layer i at `[i*ADDR_W +: ADDR_W]`.
- `layer_addr_ram` in NUM_LAYERS×ADDR_W: same packing.
- `layer_opr1`, `layer_opr2` in NUM_LAYERS×DATA_W: same packing.
- `oLayerEna` out NUM_LAYERS: one-hot layer enable.
- `oLayerRst_n` out NUM_LAYERS: active-low reset to each layer.
- `oAddrRom`, `oAddrRam` out ADDR_W: muxed addresses.
- `oOpr1`, `oOpr2` out DATA_W: muxed MultAdder operands.
- `oLayerIdx` out clog2(NUM_LAYERS): current layer.
- `oBusy`, `oDone`, `oOverflow`, `oTimeout` out 1: status flags.

## Operation

- States: IDLE, RST, RUN, NEXT, DONE, ERR.
- Reset values (iRst=1):
  - state=IDLE.
  - All `oLayerEna`=0, all `oLayerRst_n`=0.
  - idx=0, all status flags 0.
  - Muxed buses 0.
- IDLE: on `iStart`:
  - Go to RST with idx=0.
  - Clear `oOverflow`.
  - Set `oBusy`=1.
- RST:
  - `oLayerEna[idx]`=1, `oLayerRst_n[idx]`=0 for RST_CYCLES cycles.
  - Then go to RUN with `oLayerRst_n[idx]`=1.
  - The watchdog clears on entry to RUN.
- RUN:
  - Watchdog increments each cycle.
  - If `layer_done[idx]`=1, set `oOverflow |= layer_overflow[idx]` and go to NEXT.
  - Otherwise, when the watchdog reaches TIMEOUT_CYCLES-1, go to ERR.
  - If done and timeout occur in the same cycle, done wins.
- NEXT:
  - `oLayerEna[idx]`=0, `oLayerRst_n[idx]`=0.
  - If idx==NUM_LAYERS-1, go to DONE.
  - Otherwise idx++ and go to RST.
- DONE:
  - `oDone`=1, `oBusy`=0, `oOverflow` held.
  - `iStart` clears `oDone` and re-enters RST with idx=0, same as from IDLE.
- ERR:
  - `oTimeout`=1, `oBusy`=0, all enables 0, all layer resets asserted.
  - Sticky; exits only on `iRst`.
- `iStart` is ignored in RST, RUN, NEXT and ERR.
- Mux rules:
  - The muxed buses select slice idx only while `oLayerEna[idx]`=1.
  - Otherwise they are all zeros. Never X or Z, even when layers drive Z.
- Non-active layers' `layer_done` and `layer_overflow` are ignored.

## Timing

- All control outputs are registered. Muxed buses are combinational from registered idx/ena, giving zero added latency between a layer and ROM/RAM/MultAdder.
- `iStart` at edge N:
  - `oLayerEna[0]` and `oBusy` high after N.
  - `oLayerRst_n[0]` low for edges N+1 … N+RST_CYCLES, high after N+RST_CYCLES.
- Done-to-next latency:
  - `layer_done` seen at edge M; ena[idx] drops after M+1.
  - ena[idx+1] rises after M+2. One dead cycle with all enables 0.
- Last layer done at edge M: `oDone`=1 after M+2.
- Watchdog: RUN lasting TIMEOUT_CYCLES cycles without done makes `oTimeout` visible the following cycle.
- `iRst` mid-run: all outputs are at reset values after the same edge. No partial completion is reported.

## Structure

- Shared package `tpu_pkg`:
  - State encoding localparams (IDLE=0 … ERR=5).
  - ADDR_W and DATA_W defaults.
  - Layer index constants (LAYER_CONV, LAYER_FC1, LAYER_FC2, LAYER_ARGMAX).
- One natural sub-module, `tpu_bus_mux`:
  - Parameterised one-of-N slice selector with a zero default.
  - Instantiated for rom addr, ram addr, opr1 and opr2.
- Watchdog counter and FSM stay in the top module.

## Test plan

- Nominal run: NUM_LAYERS=4, each layer model raises done 10 cycles after its reset releases → layers enabled 0,1,2,3 in order, never two at once. `oDone`=1 exactly 4×(2+10+1)+… per the stated latencies, `oOverflow`=0.
- Overflow accumulation: layer 1 asserts overflow with done, others 0 → `oOverflow`=1 in DONE. A second `iStart` with no overflow → `oOverflow`=0.
- Bus muxing: layer i drives `layer_addr_rom` slice = 0x1000×(i+1), inactive slices Z → `oAddrRom`=0x2000 while idx=1, and 0 in the dead cycle and in IDLE.
- Timeout: TIMEOUT_CYCLES=16, layer 2 never asserts done → `oTimeout`=1 after 16 RUN cycles, all `oLayerEna`=0. `iStart` ignored; `iRst` returns to IDLE.
- Reset mid-operation: assert `iRst` during layer 1 RUN → next cycle state IDLE, all enables 0, all `oLayerRst_n`=0, `oBusy`=0. Fresh `iStart` restarts at layer 0.
- Edge event: `layer_done` and watchdog expiry on the same cycle → NEXT taken, `oTimeout` stays 0. Stray `layer_done[3]` while idx=0 has no effect.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU layer scheduler: FSM encoding, bus width
// defaults and the canonical layer ordering.
package tpu_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 1024;

    localparam int LAYER_CONV   = 0;
    localparam int LAYER_FC1    = 1;
    localparam int LAYER_FC2    = 2;
    localparam int LAYER_ARGMAX = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RST  = 3'd1,
        ST_RUN  = 3'd2,
        ST_NEXT = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    // Index width that stays legal for a single-layer build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tpu_layer_scheduler_if.sv
// Bundle between the layer scheduler and the layer engines / shared buses.
// master = scheduler side, slave = layer/environment side.
interface tpu_layer_scheduler_if
    import tpu_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W
);
    localparam int IDX_W = idx_width(NUM_LAYERS);

    logic                         iStart;
    logic [NUM_LAYERS-1:0]        layer_done;
    logic [NUM_LAYERS-1:0]        layer_overflow;
    logic [NUM_LAYERS*ADDR_W-1:0] layer_addr_rom;
    logic [NUM_LAYERS*ADDR_W-1:0] layer_addr_ram;
    logic [NUM_LAYERS*DATA_W-1:0] layer_opr1;
    logic [NUM_LAYERS*DATA_W-1:0] layer_opr2;

    logic [NUM_LAYERS-1:0]        oLayerEna;
    logic [NUM_LAYERS-1:0]        oLayerRst_n;
    logic [ADDR_W-1:0]            oAddrRom;
    logic [ADDR_W-1:0]            oAddrRam;
    logic [DATA_W-1:0]            oOpr1;
    logic [DATA_W-1:0]            oOpr2;
    logic [IDX_W-1:0]             oLayerIdx;
    logic                         oBusy;
    logic                         oDone;
    logic                         oOverflow;
    logic                         oTimeout;

    modport master (
        input  iStart, layer_done, layer_overflow,
               layer_addr_rom, layer_addr_ram, layer_opr1, layer_opr2,
        output oLayerEna, oLayerRst_n, oAddrRom, oAddrRam, oOpr1, oOpr2,
               oLayerIdx, oBusy, oDone, oOverflow, oTimeout
    );

    modport slave (
        output iStart, layer_done, layer_overflow,
               layer_addr_rom, layer_addr_ram, layer_opr1, layer_opr2,
        input  oLayerEna, oLayerRst_n, oAddrRom, oAddrRam, oOpr1, oOpr2,
               oLayerIdx, oBusy, oDone, oOverflow, oTimeout
    );

endinterface

// File: rtl/tpu_bus_mux.sv
// One-of-N slice selector: passes slice `sel` of a flattened bus while `en`
// is high, otherwise drives zeros so an idle bus never carries layer junk.
module tpu_bus_mux #(
    parameter int N     = 4,
    parameter int W     = 32,
    parameter int SEL_W = 2
) (
    input  logic [N*W-1:0]   slices,
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [W-1:0]     y
);

    always_comb begin
        // NOTE: default assignment first so every path drives y and no latch is inferred.
        y = '0;
        if (en) begin
            for (int i = 0; i < N; i++) begin
                if (sel == SEL_W'(i)) begin
                    y = slices[i*W +: W];
                end
            end
        end
    end

endmodule

// File: rtl/tpu_layer_scheduler.sv
// Sequences the layer engines one at a time (reset, run, wait for done),
// accumulates overflow, guards each run with a watchdog and muxes the shared buses.
module tpu_layer_scheduler
    import tpu_pkg::*;
#(
    parameter int NUM_LAYERS     = 4,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int RST_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic                   clk,
    input logic                   iRst,
    tpu_layer_scheduler_if.master bus
);

    localparam int IDX_W = idx_width(NUM_LAYERS);
    localparam int RC_W  = $clog2(RST_CYCLES) + 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES) + 1;

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic [NUM_LAYERS-1:0] ena;
    logic [NUM_LAYERS-1:0] rst_n;
    logic [RC_W-1:0]       rst_cnt;
    logic [WD_W-1:0]       wdog;
    logic                  next_drop;
    logic                  busy;
    logic                  done;
    logic                  ovf;
    logic                  tmo;
    logic                  active;

    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
        if (iRst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            ena       <= '0;
            rst_n     <= '0;
            rst_cnt   <= '0;
            wdog      <= '0;
            next_drop <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            tmo       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.iStart) begin
                        state   <= ST_RST;
                        idx     <= '0;
                        ena     <= NUM_LAYERS'(1);
                        rst_n   <= '0;
                        rst_cnt <= '0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        ovf     <= 1'b0;
                    end
                end
                ST_RST: begin
                    if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
                        state <= ST_RUN;
                        rst_n <= ena;
                        wdog  <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + RC_W'(1);
                    end
                end
                ST_RUN: begin
                    // Done is checked first so it wins over a simultaneous watchdog expiry.
                    if (bus.layer_done[idx]) begin
                        ovf       <= ovf | bus.layer_overflow[idx];
                        state     <= ST_NEXT;
                        next_drop <= 1'b0;
                    end else if (wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        state <= ST_ERR;
                        ena   <= '0;
                        rst_n <= '0;
                        busy  <= 1'b0;
                        tmo   <= 1'b1;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                ST_NEXT: begin
                    // First cycle drops the finished layer; the second is the all-off dead cycle.
                    if (!next_drop) begin
                        ena       <= '0;
                        rst_n     <= '0;
                        next_drop <= 1'b1;
                    end else if (idx == IDX_W'(NUM_LAYERS - 1)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state   <= ST_RST;
                        idx     <= idx + IDX_W'(1);
                        ena     <= NUM_LAYERS'(1) << (idx + IDX_W'(1));
                        rst_cnt <= '0;
                    end
                end
                ST_ERR: begin
                    state <= ST_ERR;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign active          = ena[idx];
    assign bus.oLayerEna   = ena;
    assign bus.oLayerRst_n = rst_n;
    assign bus.oLayerIdx   = idx;
    assign bus.oBusy       = busy;
    assign bus.oDone       = done;
    assign bus.oOverflow   = ovf;
    assign bus.oTimeout    = tmo;

    tpu_bus_mux #(.N(NUM_LAYERS), .W(ADDR_W), .SEL_W(IDX_W)) u_rom_mux (
        .slices (bus.layer_addr_rom),
        .sel    (idx),
        .en     (active),
        .y      (bus.oAddrRom)
    );

    tpu_bus_mux #(.N(NUM_LAYERS), .W(ADDR_W), .SEL_W(IDX_W)) u_ram_mux (
        .slices (bus.layer_addr_ram),
        .sel    (idx),
        .en     (active),
        .y      (bus.oAddrRam)
    );

    tpu_bus_mux #(.N(NUM_LAYERS), .W(DATA_W), .SEL_W(IDX_W)) u_opr1_mux (
        .slices (bus.layer_opr1),
        .sel    (idx),
        .en     (active),
        .y      (bus.oOpr1)
    );

    tpu_bus_mux #(.N(NUM_LAYERS), .W(DATA_W), .SEL_W(IDX_W)) u_opr2_mux (
        .slices (bus.layer_opr2),
        .sel    (idx),
        .en     (active),
        .y      (bus.oOpr2)
    );

endmodule

// File: tb/tb_tpu_layer_scheduler.sv
// Scoreboard bench for tpu_layer_scheduler: stimulus queues the expected output
// snapshots of each run; a monitor pops one whenever the control outputs change.
module tb_tpu_layer_scheduler;

    localparam int NL  = 4;
    localparam int AW  = 32;
    localparam int DW  = 1024;
    localparam int RST = 2;
    localparam int TMO = 16;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    typedef struct {
        int           off;
        logic [3:0]   ena;
        logic [3:0]   rstn;
        logic [1:0]   idx;
        logic         busy;
        logic         done;
        logic         ovf;
        logic         tmo;
        logic [31:0]  rom;
        logic [31:0]  ram;
        logic [DW-1:0] opr1;
        logic [DW-1:0] opr2;
    } snap_t;

    logic clk;
    logic rst;
    int   cyc;
    int   t0;
    int   n_chk;
    int   n_fail;
    snap_t exp_q[$];

    int   dly[NL];
    bit   ovf_cfg[NL];
    bit   stray;
    int   cnt[NL];

    logic [3:0] e_ena, e_rstn;
    logic [1:0] e_idx;
    logic       e_busy, e_done, e_ovf, e_tmo;

    tpu_layer_scheduler_if #(.NUM_LAYERS(NL), .ADDR_W(AW), .DATA_W(DW)) sif ();

    tpu_layer_scheduler #(
        .NUM_LAYERS     (NL),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .RST_CYCLES     (RST),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk  (clk),
        .iRst (rst),
        .bus  (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rom_val(input int i);
        return 32'(32'h1000 * (i + 1));
    endfunction

    function automatic logic [31:0] ram_val(input int i);
        return 32'hA000_0000 | 32'(i + 1);
    endfunction

    function automatic logic [DW-1:0] opr_val(input int i, input bit second);
        logic [31:0] w;
        w = 32'(32'h0101_0101 * (i + 1));
        if (second) w = ~w;
        return {(DW/32){w}};
    endfunction

    // Layer engines: an enabled layer drives its slices; idle layers park junk there.
    always_comb begin
        sif.layer_addr_rom = '0;
        sif.layer_addr_ram = '0;
        sif.layer_opr1     = '0;
        sif.layer_opr2     = '0;
        for (int i = 0; i < NL; i++) begin
            sif.layer_addr_rom[i*AW +: AW] = sif.oLayerEna[i] ? rom_val(i) : JUNK;
            sif.layer_addr_ram[i*AW +: AW] = sif.oLayerEna[i] ? ram_val(i) : JUNK;
            sif.layer_opr1[i*DW +: DW]     = sif.oLayerEna[i] ? opr_val(i, 1'b0) : {(DW/32){JUNK}};
            sif.layer_opr2[i*DW +: DW]     = sif.oLayerEna[i] ? opr_val(i, 1'b1) : {(DW/32){JUNK}};
        end
    end

    // Done rises dly[i] RUN cycles after the layer's reset releases (dly 0 = never).
    always @(negedge clk) begin
        for (int i = 0; i < NL; i++) begin
            if (!sif.oLayerRst_n[i] || !sif.oLayerEna[i]) cnt[i] <= 0;
            else if (cnt[i] < 1000) cnt[i] <= cnt[i] + 1;
            sif.layer_done[i] <= (sif.oLayerEna[i] && sif.oLayerRst_n[i] && dly[i] != 0
                                  && cnt[i] + 1 >= dly[i]) || (i == 3 && stray);
            sif.layer_overflow[i] <= (ovf_cfg[i] && sif.oLayerEna[i] && sif.oLayerRst_n[i]
                                      && dly[i] != 0 && cnt[i] + 1 >= dly[i]) || (i == 3 && stray);
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int off);
        snap_t s;
        s.off  = off;
        s.ena  = e_ena;
        s.rstn = e_rstn;
        s.idx  = e_idx;
        s.busy = e_busy;
        s.done = e_done;
        s.ovf  = e_ovf;
        s.tmo  = e_tmo;
        s.rom  = (e_ena == 0) ? 32'h0 : rom_val(int'(e_idx));
        s.ram  = (e_ena == 0) ? 32'h0 : ram_val(int'(e_idx));
        s.opr1 = (e_ena == 0) ? '0 : opr_val(int'(e_idx), 1'b0);
        s.opr2 = (e_ena == 0) ? '0 : opr_val(int'(e_idx), 1'b1);
        exp_q.push_back(s);
    endtask

    task automatic exp_reset();
        e_ena = '0; e_rstn = '0; e_idx = '0;
        e_busy = 1'b0; e_done = 1'b0; e_ovf = 1'b0; e_tmo = 1'b0;
    endtask

    // Queue the hand-derived event timeline of one inference from iStart (offset 0).
    task automatic expect_run();
        int b = 0;
        e_busy = 1'b1; e_done = 1'b0; e_ovf = 1'b0; e_tmo = 1'b0;
        for (int k = 0; k < NL; k++) begin
            e_ena = 4'(1 << k); e_rstn = '0; e_idx = 2'(k);
            push(b);
            e_rstn = e_ena;
            push(b + RST);
            if (dly[k] == 0 || dly[k] > TMO) begin
                e_ena = '0; e_rstn = '0; e_busy = 1'b0; e_tmo = 1'b1;
                push(b + RST + TMO);
                return;
            end
            if (ovf_cfg[k] && !e_ovf) begin
                e_ovf = 1'b1;
                push(b + RST + dly[k]);
            end
            e_ena = '0; e_rstn = '0;
            push(b + RST + dly[k] + 1);
            b = b + RST + dly[k] + 2;
        end
        e_done = 1'b1; e_busy = 1'b0;
        push(b);
    endtask

    task automatic start();
        @(negedge clk);
        t0 = cyc + 1;
        sif.iStart = 1'b1;
        @(negedge clk);
        sif.iStart = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expected events never seen", exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    // Monitor: any change of the registered control outputs must match the queue head.
    initial begin
        logic [13:0] cur, prev;
        bit first;
        snap_t e;
        first = 1'b1;
        prev  = '0;
        forever begin
            @(negedge clk);
            cur = {sif.oLayerEna, sif.oLayerRst_n, sif.oLayerIdx,
                   sif.oBusy, sif.oDone, sif.oOverflow, sif.oTimeout};
            if (first || cur != prev) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected: outputs became %h at offset %0d", cur, cyc - t0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("offset@%0d", e.off), 256'(cyc - t0), 256'(e.off));
                    check($sformatf("ena@%0d", e.off), 256'(sif.oLayerEna), 256'(e.ena));
                    check($sformatf("rst_n@%0d", e.off), 256'(sif.oLayerRst_n), 256'(e.rstn));
                    check($sformatf("idx@%0d", e.off), 256'(sif.oLayerIdx), 256'(e.idx));
                    check($sformatf("busy@%0d", e.off), 256'(sif.oBusy), 256'(e.busy));
                    check($sformatf("done@%0d", e.off), 256'(sif.oDone), 256'(e.done));
                    check($sformatf("ovf@%0d", e.off), 256'(sif.oOverflow), 256'(e.ovf));
                    check($sformatf("tmo@%0d", e.off), 256'(sif.oTimeout), 256'(e.tmo));
                    check($sformatf("rom@%0d", e.off), 256'(sif.oAddrRom), 256'(e.rom));
                    check($sformatf("ram@%0d", e.off), 256'(sif.oAddrRam), 256'(e.ram));
                    for (int q = 0; q < DW / 256; q++) begin
                        check($sformatf("opr1[%0d]@%0d", q, e.off), sif.oOpr1[q*256 +: 256], e.opr1[q*256 +: 256]);
                        check($sformatf("opr2[%0d]@%0d", q, e.off), sif.oOpr2[q*256 +: 256], e.opr2[q*256 +: 256]);
                    end
                end
            end
            prev  = cur;
            first = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL global time limit reached");
        $fatal(1, "bench did not finish");
    end

    initial begin
        cyc = 0; t0 = 1; n_chk = 0; n_fail = 0;
        rst = 1'b1; sif.iStart = 1'b0; stray = 1'b0;
        for (int i = 0; i < NL; i++) begin
            dly[i] = 10;
            ovf_cfg[i] = 1'b0;
        end

        // Reset state, seen at the first negedge after the first reset edge.
        exp_reset();
        push(0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_drain(10);

        // Nominal run from IDLE: layers 0..3 in order, done at offset 56.
        expect_run();
        start();
        wait_drain(200);

        // Overflow from layer 1 only, started from DONE.
        ovf_cfg[1] = 1'b1;
        expect_run();
        start();
        wait_drain(200);
        ovf_cfg[1] = 1'b0;

        // Clean restart from DONE clears the accumulated overflow.
        expect_run();
        start();
        wait_drain(200);

        // Reset while layer 1 is running (RUN entered at offset 16).
        e_busy = 1'b1; e_done = 1'b0; e_ovf = 1'b0; e_tmo = 1'b0;
        e_ena = 4'b0001; e_rstn = 4'b0000; e_idx = 2'd0; push(0);
        e_rstn = 4'b0001; push(2);
        e_ena = 4'b0000; e_rstn = 4'b0000; push(13);
        e_ena = 4'b0010; e_idx = 2'd1; push(14);
        e_rstn = 4'b0010; push(16);
        exp_reset(); push(20);
        start();
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_drain(40);
        expect_run();
        start();
        wait_drain(200);

        // Layer 0 done on the watchdog's last cycle, plus a stray done/overflow on layer 3.
        dly[0] = TMO;
        expect_run();
        start();
        repeat (4) @(negedge clk);
        stray = 1'b1;
        repeat (8) @(negedge clk);
        stray = 1'b0;
        wait_drain(200);
        dly[0] = 10;

        // Layer 2 hangs: ERR at offset 46, iStart ignored, iRst recovers.
        dly[2] = 0;
        expect_run();
        start();
        wait_drain(200);
        @(negedge clk);
        sif.iStart = 1'b1;
        @(negedge clk);
        sif.iStart = 1'b0;
        repeat (6) @(negedge clk);
        exp_reset();
        push(0);
        @(negedge clk);
        t0 = cyc + 1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_drain(10);
        dly[2] = 10;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
